vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//  Multi-product vending sequencer. Accumulates coin credit, validates product selection
//  against a price table, runs a req/ack handshake to the dispenser mechanism, then pays
//  change through a $5 coin hopper via a second req/ack handshake. Sits between the coin
//  acceptor / keypad front end and the dispenser + hopper actuators.
// PARAMETERS
//  CREDIT_W     6     credit register width in $1 units (max credit 2^CREDIT_W-1)
//  PRICE_A      15    price of product A, $1 units, must be a multiple of 5
//  PRICE_B      20    price of product B, $1 units, must be a multiple of 5
//  TIMEOUT_CYC  1000  idle cycles before auto-refund (used only with VEND_TIMEOUT_EN)
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  reset        in   1         synchronous, active-high
//  coin         in   2         00 none, 01 $5, 10 $10, 11 invalid (ignored, no reject)
//  sel          in   2         00 none, 01 product A, 10 product B, 11 cancel/refund
//  vend_ack     in   1         dispenser done; sampled only while vend_req=1
//  chg_ack      in   1         hopper released one $5 coin; sampled only while chg_req=1
//  vend_req     out  1         dispense request, held until vend_ack
//  vend_item    out  2         01 A / 10 B while vend_req=1, else 00
//  chg_req      out  1         change request, held while credit>0 in CHANGE
//  credit       out  CREDIT_W  current credit, registered
//  coin_reject  out  1         1-cycle pulse: coin refused (busy or overflow)
//  insuf        out  1         1-cycle pulse: product selected with credit < price
//  vend_done    out  1         1-cycle pulse on the cycle after vend_ack accepted
// BEHAVIOUR
//  Reset: state=IDLE; credit, vend_req, vend_item, chg_req, coin_reject, insuf, vend_done=0.
//   Reset mid-VEND/CHANGE aborts immediately; remaining credit is discarded.
//  States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE. All outputs registered.
//  IDLE/CREDIT, valid coin: credit+=5 or 10 -> CREDIT. If sum > 2^CREDIT_W-1: credit
//   unchanged, coin_reject=1 next cycle.
//  Coin and sel in the same cycle: coin wins, sel ignored (no insuf pulse).
//  sel=01/10 with credit>=price: credit-=price, vend_req=1, vend_item=sel next cycle -> VEND.
//   Credit<price: insuf=1 next cycle, state unchanged. sel in IDLE with price>0 -> insuf.
//  sel=11 in CREDIT -> CHANGE; in IDLE -> no effect.
//  VEND: vend_req/vend_item held stable until vend_ack=1 sampled; at that edge vend_req=0,
//   vend_item=00, vend_done=1 next cycle; credit>0 -> CHANGE, else -> IDLE. No timeout.
//  CHANGE: chg_req=1; each sampled chg_ack: credit-=5. On the ack that makes credit 0,
//   chg_req drops at the same edge -> IDLE. chg_ack held high = one coin per cycle.
//  Coins in VEND/CHANGE: not added, coin_reject pulse. sel in VEND/CHANGE ignored.
//  Credit is always a multiple of 5; no arithmetic underflow is possible.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: idle counter runs in CREDIT, cleared by any valid coin or any
//   nonzero sel; on reaching TIMEOUT_CYC -> CHANGE (auto-refund). Counter cleared on exit.
//  Undefined: no counter logic; CREDIT holds indefinitely; TIMEOUT_CYC unused.
// TESTING
//  Reset with all inputs 0 -> all outputs 0, credit=0; reset during CHANGE -> chg_req=0 next.
//  $10,$5, sel=A -> credit 15, vend_req=1 item=01, ack -> vend_done, credit 0, IDLE, no chg_req.
//  $10,$10,$5 (25), sel=B -> vend B; after ack chg_req=1; one chg_ack -> credit 0, chg_req=0.
//  $5, sel=A -> insuf pulse, credit stays 5; sel=11 -> CHANGE, one ack, IDLE.
//  Coin during VEND and coin pushing credit past 63 -> coin_reject pulse, credit unchanged.
//  VEND_TIMEOUT_EN, TIMEOUT_CYC=8: $10 then idle 8 cycles -> chg_req=1, two acks -> IDLE.

Source files
------------

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit vending sequencer with dispenser and $5 change-hopper handshakes.
// Define VEND_TIMEOUT_EN to auto-refund credit left idle for TIMEOUT_CYC cycles.
module vend_sequencer #(
   parameter int CREDIT_W    = 6,
   parameter int PRICE_A     = 15,
   parameter int PRICE_B     = 20,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          coin,
   input  logic [1:0]          sel,
   input  logic                vend_ack,
   input  logic                chg_ack,
   output logic                vend_req,
   output logic [1:0]          vend_item,
   output logic                chg_req,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                insuf,
   output logic                vend_done
);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   localparam int                 SUM_W      = CREDIT_W + 1;
   localparam logic [SUM_W-1:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [CREDIT_W-1:0] COIN5     = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
   localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                vend_req_q, vend_req_d;
   logic [1:0]          vend_item_q, vend_item_d;
   logic                chg_req_q, chg_req_d;
   logic                coin_reject_q, coin_reject_d;
   logic                insuf_q, insuf_d;
   logic                vend_done_q, vend_done_d;

   logic                coin_valid;
   logic [SUM_W-1:0]    coin_val;
   logic [SUM_W-1:0]    coin_sum;
   logic                coin_ovf;
   logic                sel_buy;
   logic [CREDIT_W-1:0] price;
   logic                can_buy;
   logic                busy;
   logic                timeout_hit;

   always_comb begin
      coin_valid = (coin == 2'b01) || (coin == 2'b10);
      coin_val   = (coin == 2'b10) ? SUM_W'(10) : (coin == 2'b01) ? SUM_W'(5) : '0;
      coin_sum   = {1'b0, credit_q} + coin_val;
      coin_ovf   = coin_sum > CREDIT_MAX;
      sel_buy    = (sel == 2'b01) || (sel == 2'b10);
      price      = (sel == 2'b01) ? PRICE_A_C : PRICE_B_C;
      can_buy    = credit_q >= price;
      busy       = (state_q == VEND) || (state_q == CHANGE);
   end

`ifdef VEND_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMR_W-1:0] idle_cnt_q, idle_cnt_d;

   // Counts only truly idle CREDIT cycles; any activity or leaving CREDIT zeroes it.
   always_comb begin
      idle_cnt_d  = '0;
      timeout_hit = 1'b0;
      if (state_q == CREDIT && !coin_valid && sel == 2'b00) begin
         if (idle_cnt_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) idle_cnt_q <= '0;
      else       idle_cnt_q <= idle_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and credit arithmetic.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      case (state_q)
         IDLE, CREDIT: begin
            if (coin_valid) begin
               if (!coin_ovf) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = CREDIT;
               end
            end else if (sel_buy) begin
               if (can_buy) begin
                  credit_d = credit_q - price;
                  state_d  = VEND;
               end
            end else if ((sel == 2'b11 && state_q == CREDIT) || timeout_hit) begin
               state_d = CHANGE;
            end
         end
         VEND: begin
            if (vend_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            if (chg_ack) begin
               credit_d = credit_q - COIN5;
               if (credit_q == COIN5) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values; the requests follow the state being entered so they register with it.
   always_comb begin
      vend_req_d    = (state_d == VEND);
      vend_item_d   = 2'b00;
      if (state_d == VEND) vend_item_d = (state_q == VEND) ? vend_item_q : sel;
      chg_req_d     = (state_d == CHANGE);
      coin_reject_d = coin_valid && (busy || coin_ovf);
      insuf_d       = !busy && !coin_valid && sel_buy && !can_buy;
      vend_done_d   = (state_q == VEND) && vend_ack;
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked branch, not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         vend_req_q    <= 1'b0;
         vend_item_q   <= 2'b00;
         chg_req_q     <= 1'b0;
         coin_reject_q <= 1'b0;
         insuf_q       <= 1'b0;
         vend_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         vend_req_q    <= vend_req_d;
         vend_item_q   <= vend_item_d;
         chg_req_q     <= chg_req_d;
         coin_reject_q <= coin_reject_d;
         insuf_q       <= insuf_d;
         vend_done_q   <= vend_done_d;
      end
   end

   assign vend_req    = vend_req_q;
   assign vend_item   = vend_item_q;
   assign chg_req     = chg_req_q;
   assign credit      = credit_q;
   assign coin_reject = coin_reject_q;
   assign insuf       = insuf_q;
   assign vend_done   = vend_done_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Testbench for vend_sequencer: directed scenarios plus random traffic against a credit-ledger model.
// Compile with +define+VEND_TIMEOUT_EN to also cover the auto-refund path (TIMEOUT_CYC=8).
module tb_vend_sequencer;

   localparam int CW = 6;
   localparam int PA = 15;
   localparam int PB = 20;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    coin;
   logic [1:0]    sel;
   logic          vend_ack;
   logic          chg_ack;
   logic          vend_req;
   logic [1:0]    vend_item;
   logic          chg_req;
   logic [CW-1:0] credit;
   logic          coin_reject;
   logic          insuf;
   logic          vend_done;

   int n_pass  = 0;
   int n_total = 0;

   // Ledger model: money held, and whether a dispense or a refund is outstanding.
   int m_credit;
   int m_item;
   int m_idle;
   bit m_vending;
   bit m_refunding;
   bit e_reject;
   bit e_insuf;
   bit e_done;

   vend_sequencer #(
      .CREDIT_W   (CW),
      .PRICE_A    (PA),
      .PRICE_B    (PB),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .coin       (coin),
      .sel        (sel),
      .vend_ack   (vend_ack),
      .chg_ack    (chg_ack),
      .vend_req   (vend_req),
      .vend_item  (vend_item),
      .chg_req    (chg_req),
      .credit     (credit),
      .coin_reject(coin_reject),
      .insuf      (insuf),
      .vend_done  (vend_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   // Output vector order: vend_req, vend_item, chg_req, credit, coin_reject, insuf, vend_done.
   function automatic logic [12:0] obs();
      return {vend_req, vend_item, chg_req, credit, coin_reject, insuf, vend_done};
   endfunction

   function automatic logic [12:0] ev(input logic vr, input logic [1:0] vi, input logic cr,
                                      input int cred, input logic rj, input logic ins, input logic dn);
      return {vr, vi, cr, CW'(cred), rj, ins, dn};
   endfunction

   task automatic cyc(input logic [1:0] c, input logic [1:0] s, input logic va, input logic ca);
      coin = c; sel = s; vend_ack = va; chg_ack = ca;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if (obs() !== 13'd0) $display("FAIL reset_outputs: got %h want %h", obs(), 13'd0);
      else n_pass++;
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b00, 2'b11, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 1, 10, 0, 0, 0)) $display("FAIL reset_pre_change: got %h want %h", obs(), ev(0, 2'b00, 1, 10, 0, 0, 0));
      else n_pass++;
      reset = 1'b1;
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      reset = 1'b0;
      n_total++;
      if (obs() !== 13'd0) $display("FAIL reset_in_change: got %h want %h", obs(), 13'd0);
      else n_pass++;
   endtask

   task automatic test_vend_a();
      do_reset();
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 15, 0, 0, 0)) $display("FAIL vend_a_credit: got %h want %h", obs(), ev(0, 2'b00, 0, 15, 0, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b01, 1'b0, 1'b0);
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(1, 2'b01, 0, 0, 0, 0, 0)) $display("FAIL vend_a_req_held: got %h want %h", obs(), ev(1, 2'b01, 0, 0, 0, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b1, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 0, 0, 0, 1)) $display("FAIL vend_a_done: got %h want %h", obs(), ev(0, 2'b00, 0, 0, 0, 0, 1));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== 13'd0) $display("FAIL vend_a_idle: got %h want %h", obs(), 13'd0);
      else n_pass++;
   endtask

   task automatic test_vend_b_change();
      do_reset();
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 1'b0, 1'b0);
      cyc(2'b00, 2'b10, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(1, 2'b10, 0, 5, 0, 0, 0)) $display("FAIL vend_b_req: got %h want %h", obs(), ev(1, 2'b10, 0, 5, 0, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b1, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 1, 5, 0, 0, 1)) $display("FAIL vend_b_to_change: got %h want %h", obs(), ev(0, 2'b00, 1, 5, 0, 0, 1));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b0, 1'b1);
      n_total++;
      if (obs() !== 13'd0) $display("FAIL vend_b_change_done: got %h want %h", obs(), 13'd0);
      else n_pass++;
   endtask

   task automatic test_insuf_cancel();
      do_reset();
      cyc(2'b00, 2'b01, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 0, 0, 1, 0)) $display("FAIL insuf_idle: got %h want %h", obs(), ev(0, 2'b00, 0, 0, 0, 1, 0));
      else n_pass++;
      cyc(2'b01, 2'b00, 1'b0, 1'b0);
      cyc(2'b00, 2'b01, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 5, 0, 1, 0)) $display("FAIL insuf_pulse: got %h want %h", obs(), ev(0, 2'b00, 0, 5, 0, 1, 0));
      else n_pass++;
      cyc(2'b00, 2'b11, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 1, 5, 0, 0, 0)) $display("FAIL cancel_change: got %h want %h", obs(), ev(0, 2'b00, 1, 5, 0, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b0, 1'b1);
      n_total++;
      if (obs() !== 13'd0) $display("FAIL cancel_idle: got %h want %h", obs(), 13'd0);
      else n_pass++;
   endtask

   task automatic test_coin_and_sel();
      do_reset();
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b01, 2'b01, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 15, 0, 0, 0)) $display("FAIL coin_wins_sel: got %h want %h", obs(), ev(0, 2'b00, 0, 15, 0, 0, 0));
      else n_pass++;
   endtask

   task automatic test_reject();
      do_reset();
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b00, 2'b01, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(1, 2'b01, 0, 5, 1, 0, 0)) $display("FAIL reject_in_vend: got %h want %h", obs(), ev(1, 2'b01, 0, 5, 1, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b1, 1'b0);
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 1, 5, 1, 0, 0)) $display("FAIL reject_in_change: got %h want %h", obs(), ev(0, 2'b00, 1, 5, 1, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cyc(2'b10, 2'b00, 1'b0, 1'b0);
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 60, 1, 0, 0)) $display("FAIL overflow_10: got %h want %h", obs(), ev(0, 2'b00, 0, 60, 1, 0, 0));
      else n_pass++;
      cyc(2'b01, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 60, 1, 0, 0)) $display("FAIL overflow_5: got %h want %h", obs(), ev(0, 2'b00, 0, 60, 1, 0, 0));
      else n_pass++;
      cyc(2'b11, 2'b11, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 1, 60, 0, 0, 0)) $display("FAIL invalid_coin_cancel: got %h want %h", obs(), ev(0, 2'b00, 1, 60, 0, 0, 0));
      else n_pass++;
      for (int i = 0; i < 12; i++) cyc(2'b00, 2'b00, 1'b0, 1'b1);
      n_total++;
      if (obs() !== 13'd0) $display("FAIL drain_12_coins: got %h want %h", obs(), 13'd0);
      else n_pass++;
   endtask

`ifdef VEND_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      cyc(2'b10, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < TO - 1; i++) cyc(2'b00, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 0, 10, 0, 0, 0)) $display("FAIL timeout_early: got %h want %h", obs(), ev(0, 2'b00, 0, 10, 0, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ev(0, 2'b00, 1, 10, 0, 0, 0)) $display("FAIL timeout_refund: got %h want %h", obs(), ev(0, 2'b00, 1, 10, 0, 0, 0));
      else n_pass++;
      cyc(2'b00, 2'b00, 1'b0, 1'b1);
      cyc(2'b00, 2'b00, 1'b0, 1'b1);
      n_total++;
      if (obs() !== 13'd0) $display("FAIL timeout_idle: got %h want %h", obs(), 13'd0);
      else n_pass++;
   endtask
`endif

   // Apply one cycle's inputs to the ledger model, using the rules for what money does.
   task automatic model_step();
      int val;
      int price;
      e_reject = 1'b0;
      e_insuf  = 1'b0;
      e_done   = 1'b0;
      val = (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
      if (m_vending) begin
         m_idle = 0;
         if (val != 0) e_reject = 1'b1;
         if (vend_ack) begin
            m_vending   = 1'b0;
            e_done      = 1'b1;
            m_refunding = (m_credit > 0);
         end
      end else if (m_refunding) begin
         m_idle = 0;
         if (val != 0) e_reject = 1'b1;
         if (chg_ack) begin
            m_credit    = m_credit - 5;
            m_refunding = (m_credit > 0);
         end
      end else if (val != 0) begin
         m_idle = 0;
         if (m_credit + val > (1 << CW) - 1) e_reject = 1'b1;
         else m_credit = m_credit + val;
      end else if (sel == 2'b01 || sel == 2'b10) begin
         m_idle = 0;
         price  = (sel == 2'b01) ? PA : PB;
         if (m_credit >= price) begin
            m_credit  = m_credit - price;
            m_vending = 1'b1;
            m_item    = int'(sel);
         end else begin
            e_insuf = 1'b1;
         end
      end else if (sel == 2'b11) begin
         m_idle = 0;
         if (m_credit > 0) m_refunding = 1'b1;
      end else if (m_credit > 0) begin
`ifdef VEND_TIMEOUT_EN
         m_idle++;
         if (m_idle == TO) begin
            m_idle      = 0;
            m_refunding = 1'b1;
         end
`endif
      end
   endtask

   task automatic test_random();
      logic [12:0] want;
      do_reset();
      m_credit = 0; m_item = 0; m_idle = 0;
      m_vending = 1'b0; m_refunding = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         coin     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         sel      = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         vend_ack = ($urandom_range(0, 2) == 0);
         chg_ack  = ($urandom_range(0, 1) == 0);
         @(posedge clk);
         model_step();
         #1;
         want = ev(m_vending, m_vending ? 2'(m_item) : 2'b00, m_refunding, m_credit, e_reject, e_insuf, e_done);
         n_total++;
         if (obs() !== want) $display("FAIL random_cycle_%0d: got %h want %h", n, obs(), want);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; coin = 2'b00; sel = 2'b00; vend_ack = 1'b0; chg_ack = 1'b0;
      test_reset();
      test_vend_a();
      test_vend_b_change();
      test_insuf_cancel();
      test_coin_and_sel();
      test_reject();
`ifdef VEND_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
